// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width,
// ALU op codes and FSM state encoding.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;
  localparam logic [OP_W-1:0] OP_SLL = 3'b110;
  localparam logic [OP_W-1:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU.
// Ports: a, b (operands), op (ALU control code) -> result_c, zero_c.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result_c,
  output logic              zero_c
);

  always_comb begin
    result_c = '0;
    case (op)
      OP_ADD:  result_c = a + b;
      OP_SUB:  result_c = a - b;
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_SLT:  result_c = DATA_W'($signed(a) < $signed(b));
      OP_SLL:  result_c = a << b[4:0];
      OP_SRL:  result_c = a >> b[4:0];
      default: result_c = '0;
    endcase
    zero_c = (result_c == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Ports: clk, reset_n (async active-low); per requester N:
//   reqN_valid/ready/a/b/op (request), rspN_valid/ready/result/zero
//   (response); busy (not idle), grant_id (current owner while busy).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              busy,
  output logic              grant_id
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;

  logic              grant_sel;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // ALU sees only the latched operands, never the request ports.
  alu_arbiter_alu u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result_c (alu_result),
    .zero_c   (alu_zero)
  );

  // Next-state, grant selection and ready generation.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;

    // A lone requester wins outright; contention goes to the pointer.
    grant_sel = prio_q;
    if (req0_valid && !req1_valid) grant_sel = 1'b0;
    else if (req1_valid && !req0_valid) grant_sel = 1'b1;

    // reset_n gates ready so nothing is offered while reset is held.
    accept     = reset_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && req0_valid && !grant_sel;
    req1_ready = accept && req1_valid && grant_sel;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_d = grant_sel;
          prio_d  = ~grant_sel;
          a_d     = grant_sel ? req1_a  : req0_a;
          b_d     = grant_sel ? req1_b  : req0_b;
          op_d    = grant_sel ? req1_op : req0_op;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (grant_q ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    rsp0_valid_d = (state_d == ST_RESP) && !grant_d;
    rsp1_valid_d = (state_d == ST_RESP) && grant_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prio_q       <= INIT_PRIO;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      busy_q       <= busy_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;

endmodule
